wt_dcache_reuse_pred: RTL

// - Signature-based reuse predictor feeding the dcache PLRU insertion-position input (pred_result).
// - Hashes miss PC to a signature; 2-bit saturating counter table (SHCT) predicts if a refilled line is reused.
// - Trained by dcache hits (reuse) and refill evictions (dead line); pred 0 -> insert as LRU, else as MRU.
// - Sits between the miss unit (request/refill) and the PLRU block; supports one outstanding miss.

---
 rtl/wt_dcache_reuse_pred_pkg.sv | 21 ++
 rtl/wt_dcache_reuse_pred_shct.sv | 47 ++++
 rtl/wt_dcache_reuse_pred.sv | 89 ++++++++
 3 files changed

// File: rtl/wt_dcache_reuse_pred_pkg.sv
// rtl/wt_dcache_reuse_pred_pkg.sv - shared types and constants for the dcache reuse predictor
package wt_dcache_reuse_pred_pkg;

  localparam int DCACHE_NUM_WORDS = 16;
  localparam int DCACHE_SET_ASSOC = 4;
  localparam int SIG_W            = 6;

  typedef logic [1:0] shct_ctr_t;

  typedef struct packed {
    logic             valid;
    logic             reused;
    logic [SIG_W-1:0] sig;
  } line_meta_t;

  typedef enum logic {IDLE, PEND} pred_state_e;

  localparam shct_ctr_t PRED_DEAD    = 2'b00;
  localparam shct_ctr_t PRED_DEFAULT = 2'b01;

endpackage

// File: rtl/wt_dcache_reuse_pred_shct.sv
// rtl/wt_dcache_reuse_pred_shct.sv - signature history counter table with saturating inc/dec
module wt_dcache_reuse_pred_shct
  import wt_dcache_reuse_pred_pkg::*;
#(
  parameter int SIG_WIDTH = SIG_W
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [SIG_WIDTH-1:0] rd_sig_i,
  output shct_ctr_t            rd_data_o,
  input  logic                 inc_en_i,
  input  logic [SIG_WIDTH-1:0] inc_sig_i,
  input  logic                 dec_en_i,
  input  logic [SIG_WIDTH-1:0] dec_sig_i
);

  localparam int N = 2**SIG_WIDTH;

  shct_ctr_t ctr_q [N];
  shct_ctr_t ctr_d [N];

  // inc and dec on one entry cancel out
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ctr_d[i] = ctr_q[i];
      if (inc_en_i && inc_sig_i == SIG_WIDTH'(i) &&
          !(dec_en_i && dec_sig_i == SIG_WIDTH'(i))) begin
        if (ctr_q[i] != 2'b11) ctr_d[i] = ctr_q[i] + 2'b01;
      end else if (dec_en_i && dec_sig_i == SIG_WIDTH'(i) &&
                   !(inc_en_i && inc_sig_i == SIG_WIDTH'(i))) begin
        if (ctr_q[i] != 2'b00) ctr_d[i] = ctr_q[i] - 2'b01;
      end
    end
  end

  // read returns the post-update value so a same-cycle capture sees training
  assign rd_data_o = ctr_d[rd_sig_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N; i++) ctr_q[i] <= PRED_DEFAULT;
    end else begin
      for (int i = 0; i < N; i++) ctr_q[i] <= ctr_d[i];
    end
  end

endmodule

// File: rtl/wt_dcache_reuse_pred.sv
// rtl/wt_dcache_reuse_pred.sv - signature reuse predictor driving PLRU insertion position
module wt_dcache_reuse_pred
  import wt_dcache_reuse_pred_pkg::*;
#(
  parameter int SIG_WIDTH = SIG_W,
  parameter int NUM_SETS  = DCACHE_NUM_WORDS,
  parameter int NUM_WAYS  = DCACHE_SET_ASSOC,
  parameter int PC_WIDTH  = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        pred_en_i,
  input  logic                        miss_req_i,
  input  logic [PC_WIDTH-1:0]         miss_pc_i,
  output logic                        miss_req_ready_o,
  input  logic                        refill_i,
  input  logic [$clog2(NUM_SETS)-1:0] refill_idx_i,
  input  logic [$clog2(NUM_WAYS)-1:0] refill_way_i,
  input  logic                        hit_i,
  input  logic [$clog2(NUM_SETS)-1:0] hit_idx_i,
  input  logic [$clog2(NUM_WAYS)-1:0] hit_way_i,
  output logic [1:0]                  pred_result_o
);

  pred_state_e           state_q;
  shct_ctr_t             pred_q;
  shct_ctr_t             shct_rd;
  logic [SIG_WIDTH-1:0]  sig, sig_q;
  line_meta_t            meta_q [NUM_SETS][NUM_WAYS];
  line_meta_t            hit_meta, vic_meta;
  logic                  hit_train, dead_train;
  logic                  unused_pc;

  assign sig = miss_pc_i[SIG_WIDTH+1:2] ^ miss_pc_i[2*SIG_WIDTH+1:SIG_WIDTH+2];
  assign unused_pc = ^{miss_pc_i[PC_WIDTH-1:2*SIG_WIDTH+2], miss_pc_i[1:0]};

  assign hit_meta   = meta_q[hit_idx_i][hit_way_i];
  assign vic_meta   = meta_q[refill_idx_i][refill_way_i];
  assign hit_train  = pred_en_i && !flush_i && hit_i && hit_meta.valid && !hit_meta.reused;
  assign dead_train = pred_en_i && !flush_i && refill_i && state_q == PEND &&
                      vic_meta.valid && !vic_meta.reused;

  wt_dcache_reuse_pred_shct #(.SIG_WIDTH(SIG_WIDTH)) i_shct (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_sig_i  (sig),
    .rd_data_o (shct_rd),
    .inc_en_i  (hit_train),
    .inc_sig_i (hit_meta.sig),
    .dec_en_i  (dead_train),
    .dec_sig_i (vic_meta.sig)
  );

  assign miss_req_ready_o = (state_q == IDLE);
  assign pred_result_o    = !pred_en_i ? 2'b11 : (state_q == PEND ? pred_q : PRED_DEFAULT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      pred_q  <= PRED_DEFAULT;
      sig_q   <= '0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) meta_q[s][w] <= '0;
    end else if (flush_i) begin
      state_q <= IDLE;
      pred_q  <= PRED_DEFAULT;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) meta_q[s][w] <= '0;
    end else begin
      if (hit_train) meta_q[hit_idx_i][hit_way_i].reused <= 1'b1;
      // refill is ordered after hit so it owns a shared slot
      if (refill_i) begin
        if (state_q == PEND) meta_q[refill_idx_i][refill_way_i] <= '{valid: 1'b1, reused: 1'b0, sig: sig_q};
        else                 meta_q[refill_idx_i][refill_way_i] <= '0;
      end
      case (state_q)
        IDLE: if (miss_req_i) begin
          state_q <= PEND;
          sig_q   <= sig;
          pred_q  <= shct_rd;
        end
        PEND: if (refill_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
